// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter: FSM encoding, default addresses,
// transfer length and the HRAM window the CPU may still reach during a transfer.
package oam_dma_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RD    = 3'd2,
    ST_LAT   = 3'd3,
    ST_WR    = 3'd4
  } dmaState_t;

  localparam int unsigned DMA_LEN_DEFAULT      = 160;
  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
  localparam logic [15:0] OAM_BASE_DEFAULT     = 16'hFE00;
  localparam logic [15:0] HRAM_LO              = 16'hFF80;
  localparam logic [15:0] HRAM_HI              = 16'hFFFE;

  function automatic logic isHram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares one MMU port between the CPU and an OAM DMA engine that copies
// DMA_LEN bytes from {srcHi, 8'hxx} to OAM_BASE, one byte every three cycles.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int unsigned DMA_LEN      = DMA_LEN_DEFAULT,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_BASE     = OAM_BASE_DEFAULT
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMmuAddr,
  output logic        oMmuWe,
  output logic [7:0]  oMmuData,
  input  logic [7:0]  iMmuData,
  output logic        oDmaActive,
  output dmaState_t   oFsmState
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dmaState_t  state, stateNext;
  logic [7:0] counter, counterNext;
  logic [7:0] srcHi, srcHiNext;
  logic [7:0] dataReg, dataRegNext;
  logic       prevCpuOwner;

  logic cpuHram;
  logic dmaReq;
  logic dmaActive;
  logic stall;
  logic cpuOwns;

  assign cpuHram   = isHram(iCpuAddr);
  assign dmaReq    = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
  assign dmaActive = (state != ST_IDLE);
  // An HRAM access only costs the DMA a cycle when it wants the port itself.
  assign stall     = cpuHram && ((state == ST_RD) || (state == ST_WR));
  assign cpuOwns   = iReset || !dmaActive || cpuHram;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= ST_IDLE;
      counter      <= 8'h00;
      srcHi        <= 8'h00;
      dataReg      <= 8'h00;
      prevCpuOwner <= 1'b1;
    end else begin
      state        <= stateNext;
      counter      <= counterNext;
      srcHi        <= srcHiNext;
      dataReg      <= dataRegNext;
      prevCpuOwner <= cpuOwns;
    end
  end

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    srcHiNext   = srcHi;
    dataRegNext = dataReg;
    case (state)
      ST_IDLE: begin
        if (dmaReq) begin
          srcHiNext   = iCpuData;
          counterNext = 8'h00;
          stateNext   = ST_START;
        end
      end
      ST_START: begin
        if (dmaReq) begin
          srcHiNext   = iCpuData;
          counterNext = 8'h00;
          stateNext   = ST_START;
        end else begin
          stateNext = ST_RD;
        end
      end
      ST_RD: begin
        if (!stall) stateNext = ST_LAT;
      end
      ST_LAT: begin
        if (dmaReq) begin
          srcHiNext   = iCpuData;
          counterNext = 8'h00;
          stateNext   = ST_START;
        end else begin
          dataRegNext = iMmuData;
          stateNext   = ST_WR;
        end
      end
      ST_WR: begin
        if (!stall) begin
          if (counter == LAST_IDX) begin
            stateNext = ST_IDLE;
          end else begin
            counterNext = counter + 8'h01;
            stateNext   = ST_RD;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // START and LAT park a harmless read of the source byte on the port.
  always_comb begin
    oMmuAddr = iCpuAddr;
    oMmuWe   = iCpuWe;
    oMmuData = iCpuData;
    if (!cpuOwns) begin
      if (state == ST_WR) begin
        oMmuAddr = OAM_BASE + {8'h00, counter};
        oMmuWe   = 1'b1;
        oMmuData = dataReg;
      end else begin
        oMmuAddr = {srcHi, counter};
        oMmuWe   = 1'b0;
        oMmuData = dataReg;
      end
    end
  end

  assign oCpuData   = prevCpuOwner ? iMmuData : 8'hFF;
  assign oDmaActive = dmaActive;
  assign oFsmState  = state;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: a 64 KiB memory model behind the MMU port and a
// transfer-level reference (byte copies, cycle totals, stall accounting).
module tb_oam_dma_arbiter;
  import oam_dma_arbiter_pkg::*;

  localparam int LEN           = 160;
  localparam int ACTIVE_CYCLES = 1 + 3 * LEN;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic [15:0] oMmuAddr;
  logic        oMmuWe;
  logic [7:0]  oMmuData;
  logic [7:0]  iMmuData;
  logic        oDmaActive;
  dmaState_t   oFsmState;

  always #5 iClock = ~iClock;

  oam_dma_arbiter dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iCpuAddr  (iCpuAddr),
    .iCpuWe    (iCpuWe),
    .iCpuData  (iCpuData),
    .oCpuData  (oCpuData),
    .oMmuAddr  (oMmuAddr),
    .oMmuWe    (oMmuWe),
    .oMmuData  (oMmuData),
    .iMmuData  (iMmuData),
    .oDmaActive(oDmaActive),
    .oFsmState (oFsmState)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] expOam  [0:LEN-1];
  logic [7:0] expHram [0:127];
  int testsRun    = 0;
  int testsFailed = 0;
  int activeCycles;
  int oamWrites;
  bit saw1234;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the port before the edge, then let the memory respond.
  task automatic tick();
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic        act;
    #2;
    a = oMmuAddr; w = oMmuWe; d = oMmuData; act = oDmaActive;
    @(posedge iClock);
    #1;
    if (w) mem[a] = d;
    iMmuData = mem[a];
    if (act) activeCycles++;
    if (w && a >= 16'hFE00 && 32'(a) < 32'hFE00 + LEN) oamWrites++;
    if (a == 16'h1234) saw1234 = 1'b1;
  endtask

  task automatic busIdle();
    iCpuAddr = 16'h0000; iCpuWe = 1'b0; iCpuData = 8'h00;
  endtask

  task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d);
    iCpuAddr = a; iCpuWe = 1'b1; iCpuData = d;
  endtask

  task automatic clearCounters();
    activeCycles = 0; oamWrites = 0; saw1234 = 1'b0;
  endtask

  task automatic snapshot(input logic [7:0] page);
    for (int i = 0; i < LEN; i++) expOam[i] = mem[{page, 8'(i)}];
  endtask

  task automatic expectPattern();
    for (int i = 0; i < LEN; i++) expOam[i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic checkOam(input string tag);
    int bad = 0;
    for (int i = 0; i < LEN; i++) if (mem[16'(32'hFE00 + i)] !== expOam[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Trigger a transfer; returns in the first active (START) cycle.
  task automatic trigger(input logic [7:0] page);
    cpuWrite(DMA_REG_ADDR_DEFAULT, page);
    tick();
    busIdle();
  endtask

  task automatic waitDone(input string tag, input int bound);
    int n = 0;
    while (oDmaActive && n < bound) begin tick(); n++; end
    check({tag, "_done"}, 32'(oDmaActive), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [7:0]  page;
    int p, stalls, bad, j;
    logic acc, stl;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    iMmuData = 8'h00;
    clearCounters();

    // Reset: CPU passes straight through while reset is held.
    iReset = 1'b1;
    cpuWrite(16'hD000, 8'h77);
    #1;
    check("reset_pass", {oMmuAddr, 7'd0, oMmuWe, oMmuData}, {16'hD000, 7'd0, 1'b1, 8'h77});
    repeat (3) tick();
    iReset = 1'b0;
    busIdle();
    #1;
    check("reset_active", 32'(oDmaActive), 32'd0);
    check("reset_state", 32'(oFsmState), 32'(ST_IDLE));

    // IDLE passthrough with random CPU traffic.
    for (int k = 0; k < 6; k++) begin
      a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      iCpuAddr = a; iCpuWe = w; iCpuData = d;
      #1;
      check("idle_pass", {oMmuAddr, 7'd0, oMmuWe, oMmuData}, {a, 7'd0, w, d});
      tick();
    end
    cpuWrite(16'hC000, 8'h3C);
    #1;
    check("idle_c000", {oMmuAddr, 7'd0, oMmuWe, oMmuData}, {16'hC000, 7'd0, 1'b1, 8'h3C});
    tick();
    check("idle_c000_mem", 32'(mem[16'hC000]), 32'h3C);
    d = mem[16'hD123];
    iCpuAddr = 16'hD123; iCpuWe = 1'b0;
    tick();
    busIdle();
    #1;
    check("idle_read", 32'(oCpuData), 32'(d));

    // Basic transfer from C000 with the i^5A pattern.
    for (int i = 0; i < LEN; i++) mem[16'(32'hC000 + i)] = 8'(i) ^ 8'h5A;
    expectPattern();
    clearCounters();
    trigger(8'hC0);
    check("a_reg_fwd", 32'(mem[16'hFF46]), 32'hC0);
    check("a_active", 32'(oDmaActive), 32'd1);
    waitDone("a", 600);
    check("a_cycles", 32'(activeCycles), 32'(ACTIVE_CYCLES));
    check("a_writes", 32'(oamWrites), 32'(LEN));
    checkOam("a_oam");

    // Non-HRAM CPU reads during a transfer are blocked.
    page = 8'($urandom_range(8'hC2, 8'hC7));
    snapshot(page);
    clearCounters();
    trigger(page);
    repeat (10) tick();
    iCpuAddr = 16'h1234; iCpuWe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("b_read_ff", 32'(oCpuData), 32'hFF);
    end
    busIdle();
    waitDone("b", 600);
    check("b_no1234", 32'(saw1234), 32'd0);
    check("b_cycles", 32'(activeCycles), 32'(ACTIVE_CYCLES));
    checkOam("b_oam");

    // HRAM write colliding with RD of byte 20 (cycle 62 after the trigger).
    expectPattern();
    clearCounters();
    trigger(8'hC0);
    repeat (61) tick();
    cpuWrite(16'hFF90, 8'hA5);
    #1;
    check("c_hram_port", {oMmuAddr, 7'd0, oMmuWe, oMmuData}, {16'hFF90, 7'd0, 1'b1, 8'hA5});
    tick();
    busIdle();
    tick();
    iCpuAddr = 16'hFF90; iCpuWe = 1'b0;
    tick();
    busIdle();
    #1;
    check("c_hram_read", 32'(oCpuData), 32'hA5);
    waitDone("c", 600);
    check("c_cycles", 32'(activeCycles), 32'(ACTIVE_CYCLES + 1));
    check("c_hram_mem", 32'(mem[16'hFF90]), 32'hA5);
    check("c_writes", 32'(oamWrites), 32'(LEN));
    checkOam("c_oam");

    // Random HRAM traffic: only collisions with RD/WR phases cost a cycle.
    page = 8'($urandom_range(8'hC2, 8'hC7));
    snapshot(page);
    for (int k = 0; k < 128; k++) expHram[k] = mem[16'(32'hFF80 + k)];
    clearCounters();
    trigger(page);
    p = 0; stalls = 0;
    while (p < ACTIVE_CYCLES) begin
      acc = ($urandom_range(0, 3) == 0);
      if (acc) begin
        j = $urandom_range(0, 126);
        d = 8'($urandom);
        cpuWrite(16'(32'hFF80 + j), d);
        expHram[j] = d;
      end else begin
        busIdle();
      end
      stl = acc && (p > 0) && (((p - 1) % 3) != 1);
      tick();
      if (stl) stalls++;
      else p++;
    end
    busIdle();
    #1;
    check("d_done", 32'(oDmaActive), 32'd0);
    check("d_cycles", 32'(activeCycles), 32'(ACTIVE_CYCLES + stalls));
    check("d_writes", 32'(oamWrites), 32'(LEN));
    checkOam("d_oam");
    bad = 0;
    for (int k = 0; k < 127; k++) if (mem[16'(32'hFF80 + k)] !== expHram[k]) bad++;
    check("d_hram", 32'(bad), 32'd0);

    // Reset during RD of byte 50 aborts before its write.
    for (int i = 0; i < LEN; i++) mem[16'(32'hFE00 + i)] = 8'hEE;
    expectPattern();
    clearCounters();
    trigger(8'hC0);
    repeat (151) tick();
    iReset = 1'b1;
    #1;
    check("e_reset_we", 32'(oMmuWe), 32'd0);
    tick();
    iReset = 1'b0;
    #1;
    check("e_active", 32'(oDmaActive), 32'd0);
    check("e_state", 32'(oFsmState), 32'(ST_IDLE));
    repeat (5) tick();
    check("e_writes", 32'(oamWrites), 32'd50);
    bad = 0;
    for (int i = 0; i < LEN; i++) begin
      if (i < 50 && mem[16'(32'hFE00 + i)] !== expOam[i]) bad++;
      if (i >= 50 && mem[16'(32'hFE00 + i)] !== 8'hEE) bad++;
    end
    check("e_oam", 32'(bad), 32'd0);

    // Restart with C1 during LAT of byte 10 (cycle 33 after the trigger).
    snapshot(8'hC1);
    clearCounters();
    trigger(8'hC0);
    repeat (32) tick();
    cpuWrite(DMA_REG_ADDR_DEFAULT, 8'hC1);
    tick();
    busIdle();
    waitDone("f", 600);
    check("f_cycles", 32'(activeCycles), 32'(33 + ACTIVE_CYCLES));
    check("f_writes", 32'(oamWrites), 32'(10 + LEN));
    checkOam("f_oam");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 Parameter DMA_LEN, default 160, number of bytes per OAM DMA transfer.
REQ-002 Parameter DMA_REG_ADDR, default 16'hFF46, CPU address that triggers a DMA transfer.
REQ-003 Parameter OAM_BASE, default 16'hFE00, DMA destination base address.
REQ-004 iClock  in  1  single system clock; all state updates on rising edge.
REQ-005 iReset  in  1  synchronous, active-high reset.
REQ-006 iCpuAddr  in  16  CPU bus address.
REQ-007 iCpuWe  in  1  CPU write strobe.
REQ-008 iCpuData  in  8  CPU write data.
REQ-009 oCpuData  out  8  CPU read data.
REQ-010 oMmuAddr  out  16  address to the MMU.
REQ-011 oMmuWe  out  1  write strobe to the MMU.
REQ-012 oMmuData  out  8  write data to the MMU.
REQ-013 iMmuData  in  8  MMU read data, valid one cycle after the address is presented.
REQ-014 oDmaActive  out  1  high while a transfer is in progress.

Function
REQ-015 The block SHALL share the single MMU port between the CPU and an internal OAM DMA engine.
REQ-016 FSM states SHALL be IDLE, START, RD, LAT and WR.
REQ-017 In IDLE, oMmuAddr/oMmuWe/oMmuData SHALL equal iCpuAddr/iCpuWe/iCpuData combinationally.
REQ-018 A CPU write to DMA_REG_ADDR SHALL be forwarded to the MMU, latch iCpuData as source high byte, clear the byte counter to 0, and go to START on the next cycle.
REQ-019 START SHALL last one cycle and then go to RD; the DMA does not drive the port in START.
REQ-020 RD SHALL present {src_hi, counter} as a read with oMmuWe=0; the next state SHALL be LAT.
REQ-021 LAT SHALL capture iMmuData into the DMA data register; the DMA does not drive the port; the next state SHALL be WR.
REQ-022 WR SHALL present OAM_BASE+counter with oMmuWe=1 and the data register; if counter==DMA_LEN-1, the next state SHALL be IDLE, otherwise counter SHALL increment and the next state SHALL be RD.
REQ-023 oDmaActive SHALL be high in START, RD, LAT and WR; an unstalled transfer SHALL hold it high for exactly 1+3*DMA_LEN cycles (481 by default).
REQ-024 While the DMA is active, CPU accesses to 16'hFF80..16'hFFFE SHALL own the port in that cycle.
REQ-025 If such a CPU access collides with RD or WR, the DMA SHALL stall in place: no state, counter or data change.
REQ-026 While the DMA is active, CPU writes outside 16'hFF80..16'hFFFE SHALL be dropped.
REQ-027 A CPU write to DMA_REG_ADDR during an active transfer SHALL be dropped, except as stated in REQ-028.
REQ-028 A CPU write to DMA_REG_ADDR while active SHALL take effect only if issued in a non-stalling state (START/LAT) or while IDLE; it SHALL restart the transfer (new src_hi, counter=0, next state START).
REQ-029 oCpuData SHALL equal iMmuData when the CPU owned the port in the previous cycle; otherwise it SHALL equal 8'hFF.
REQ-030 The counter SHALL be 8 bits wide and never exceed DMA_LEN-1; source and destination addresses SHALL be formed by concatenation and addition with no carry into bits above 15.

Reset
REQ-031 On iReset: state=IDLE, counter=0, src_hi=8'h00, data register=8'h00, previous-owner flag=CPU.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no further DMA writes, and oDmaActive SHALL be low in the cycle after the reset edge.
REQ-033 During reset the port SHALL pass CPU signals through, as in IDLE.

Structure
REQ-034 FSM state encodings, DMA_REG_ADDR, OAM_BASE, DMA_LEN and the HRAM bounds SHALL live in the shared definitions header aDefinitions.v.
REQ-035 The block SHALL be a single module with no sub-modules.
REQ-036 The block SHALL be instantiated between dzcpu and mmu in the top level.

Verification
REQ-037 Bench case: preload 16'hC000..C09F with i^8'h5A, then CPU writes 8'hC0 to FF46 -> FE00..FE9F hold i^8'h5A, oDmaActive is high for 481 cycles, and there are exactly 160 MMU writes.
REQ-038 Bench case: during DMA, CPU reads 16'h1234 -> oCpuData=8'hFF and the MMU never sees 16'h1234.
REQ-039 Bench case: during DMA, CPU writes 8'hA5 to FF90 in an RD cycle -> FF90=8'hA5, the transfer lengthens by one cycle, and OAM contents are still correct.
REQ-040 Bench case: iReset pulsed at counter=50 -> only FE00..FE31 are written, and the FSM is in IDLE with oDmaActive low afterwards.
REQ-041 Bench case: FF46 written with 8'hC1 during LAT of byte 10 -> the transfer restarts from C100, and FE00..FE9F end with C100..C19F data.
REQ-042 Bench case: CPU write to 16'hC000 while the FSM is IDLE -> the MMU receives the same address, data and strobe in the same cycle.
